// File: rtl/ram_bist.sv
// ram_bist: march-style built-in self test around an internal single-port RAM.
// One pass writes a pattern to every word, reads every word back, compares each
// read against the expected pattern, and reports an error count and the first
// failing address. An optional single-bit fault can be planted for self-checking.
module ram_bist #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              loop,
    input  logic              inj,
    output logic [DATA_W-1:0] q,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] INJ_ADDR  = ADDR_W'(DEPTH / 2);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        mode_q, mode_d;
    logic              inj_q, inj_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              pass_q, pass_d;
    logic [DATA_W-1:0] q_q;
    logic              cmp_vld_q;
    logic [ADDR_W-1:0] cmp_addr_q;
    logic [DATA_W-1:0] wdata;
    logic              mismatch;

    // Expected word for an address: address count, its inverse, or 0x55/0xAA checkerboard.
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a);
        logic [DATA_W+ADDR_W-1:0] ext;
        logic [DATA_W-1:0]        base;
        logic [DATA_W-1:0]        alt;
        ext  = {{DATA_W{1'b0}}, a};
        base = ext[DATA_W-1:0];
        for (int i = 0; i < DATA_W; i++) begin
            alt[i] = (i[0] == a[0]);
        end
        case (m)
            2'd1:    pattern = ~base;
            2'd2:    pattern = alt;
            default: pattern = base;
        endcase
    endfunction

    // Pattern sequence used when a pass auto-restarts; mode 3 is an alias of mode 0.
    function automatic logic [1:0] next_mode(input logic [1:0] m);
        case (m)
            2'd0:    next_mode = 2'd1;
            2'd1:    next_mode = 2'd2;
            2'd2:    next_mode = 2'd0;
            default: next_mode = 2'd1;
        endcase
    endfunction

    assign wdata    = pattern(mode_q, addr_q)
                    ^ {{(DATA_W-1){1'b0}}, (inj_q && (addr_q == INJ_ADDR))};
    assign mismatch = cmp_vld_q && (q_q != pattern(mode_q, cmp_addr_q));

    // Sequencer next state plus error bookkeeping for the read just returned.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mode_d     = mode_q;
        inj_d      = inj_q;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        pass_d     = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d     = mode;
                    inj_d      = inj;
                    err_cnt_d  = '0;
                    err_addr_d = '0;
                    pass_d     = 1'b0;
                    addr_d     = '0;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = S_READ;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_READ: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE: begin
                if (loop) begin
                    mode_d  = next_mode(mode_q);
                    addr_d  = '0;
                    state_d = S_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (mismatch) begin
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
            if (err_cnt_q == 16'd0) begin
                err_addr_d = cmp_addr_q;
            end
        end
        // The last read is compared in DRAIN, so the verdict includes it.
        if (state_q == S_DRAIN) begin
            pass_d = (err_cnt_d == 16'd0);
        end
    end

    // Control and status registers, forced to idle values by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            mode_q     <= 2'd0;
            inj_q      <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            pass_q     <= 1'b0;
            cmp_vld_q  <= 1'b0;
            cmp_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mode_q     <= mode_d;
            inj_q      <= inj_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
            pass_q     <= pass_d;
            cmp_vld_q  <= (state_q == S_READ);
            cmp_addr_q <= addr_q;
        end
    end

    // RAM array write port; contents deliberately carry no reset.
    always_ff @(posedge clk) begin
        if (state_q == S_WRITE) begin
            mem[addr_q] <= wdata;
        end
    end

    // Registered RAM read data, one cycle after the address is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (state_q == S_READ) begin
            q_q <= mem[addr_q];
        end
    end

    assign q        = q_q;
    assign busy     = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);
    assign pass     = pass_q;
    assign err_cnt  = err_cnt_q;
    assign err_addr = err_addr_q;

endmodule
